// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one 40-bit divider among NREQ
// requesters, with a single operation in flight and a timeout on the divider.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req                 per-requester request, held until acked
//   req_dividend        flat dividends, 40 bits per requester
//   req_divisor         flat divisors, 41 bits per requester
//   ack                 one-hot acceptance pulse (ISSUE cycle)
//   div_start           one-cycle start pulse to the divider (ISSUE cycle)
//   div_dividend/div_divisor  latched operands, stable from ISSUE through WAIT
//   div_quotient/div_done     divider result and its completion pulse
//   resp_valid/resp_ready     response handshake
//   resp_id/resp_quotient/resp_err  response payload
module div_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*40-1:0]   req_dividend,
  input  logic [NREQ*41-1:0]   req_divisor,
  output logic [NREQ-1:0]      ack,
  output logic                 div_start,
  output logic [39:0]          div_dividend,
  output logic [40:0]          div_divisor,
  input  logic [39:0]          div_quotient,
  input  logic                 div_done,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [39:0]          resp_quotient,
  output logic                 resp_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NREQ-1:0]   ack_q;
  logic              div_start_q;
  logic [39:0]       dvd_q;
  logic [40:0]       dvs_q;
  logic              resp_valid_q;
  logic [ID_W-1:0]   resp_id_q;
  logic [39:0]       resp_quotient_q;
  logic              resp_err_q;

  // Arbitration result for the current cycle
  logic              hi_vld, lo_vld;
  logic [ID_W-1:0]   hi_idx, lo_idx;
  logic              arb_vld;
  logic [ID_W-1:0]   arb_idx;
  logic [ID_W-1:0]   ptr_d;
  logic [NREQ-1:0]   arb_onehot;
  logic [39:0]       arb_dvd;
  logic [40:0]       arb_dvs;

  // Round-robin scan from ptr with wrap-around, done as two priority scans:
  // lowest set bit at or above ptr wins; otherwise lowest set bit overall.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && !hi_vld && (i >= 32'(ptr_q))) begin
        hi_vld = 1'b1;
        hi_idx = ID_W'(i);
      end
      if (req[i] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = ID_W'(i);
      end
    end
  end

  always_comb begin
    arb_vld    = lo_vld;
    arb_idx    = hi_vld ? hi_idx : lo_idx;
    ptr_d      = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + ID_W'(1);
    arb_onehot = '0;
    arb_dvd    = '0;
    arb_dvs    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i == 32'(arb_idx)) begin
        arb_onehot[i] = 1'b1;
        arb_dvd       = req_dividend[40*i +: 40];
        arb_dvs       = req_divisor[41*i +: 41];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      cnt_q           <= '0;
      ack_q           <= '0;
      div_start_q     <= 1'b0;
      dvd_q           <= '0;
      dvs_q           <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= '0;
      resp_quotient_q <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      ack_q       <= '0;
      div_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            dvd_q       <= arb_dvd;
            dvs_q       <= arb_dvs;
            resp_id_q   <= arb_idx;
            ptr_q       <= ptr_d;
            ack_q       <= arb_onehot;
            div_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A completion in the last allowed cycle beats the timeout
          if (div_done) begin
            resp_quotient_q <= div_quotient;
            resp_err_q      <= 1'b0;
            resp_valid_q    <= 1'b1;
            state_q         <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            resp_quotient_q <= '0;
            resp_err_q      <= 1'b1;
            resp_valid_q    <= 1'b1;
            state_q         <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
      endcase
    end
  end

  assign ack           = ack_q;
  assign div_start     = div_start_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_quotient = resp_quotient_q;
  assign resp_err      = resp_err_q;

endmodule
